mc_sequencer: RTL and testbench

//  Parametrised multi-cycle control sequencer for the RV32I core; successor to the fixed-latency control FSM.

---
 rtl/mc_pkg.sv | 56 +++++
 rtl/mc_sequencer_if.sv | 18 +
 rtl/mc_wait_timer.sv | 31 +++
 rtl/mc_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_mc_sequencer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer.
package mc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE,
        CAUSE_ILLEGAL,
        CAUSE_IMEM_TO,
        CAUSE_DMEM_TO
    } trap_cause_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRCA_PC   = 2'b00;
    localparam logic [1:0] SRCA_REG  = 2'b01;
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] WB_ALU    = 2'b00;
    localparam logic [1:0] WB_MEM    = 2'b01;
    localparam logic [1:0] WB_IMM    = 2'b10;
    localparam logic [1:0] WB_PC4    = 2'b11;

    // A zero timeout still needs a 1-bit counter to keep widths legal.
    function automatic int cnt_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

    function automatic logic op_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// Instruction/data memory request-ready handshake bundle.
interface mc_mem_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_wren;
    logic dmem_ready;

    modport master (
        output imem_req, dmem_req, dmem_wren,
        input  imem_ready, dmem_ready
    );

    modport slave (
        input  imem_req, dmem_req, dmem_wren,
        output imem_ready, dmem_ready
    );
endinterface

// File: rtl/mc_wait_timer.sv
// Saturating memory-wait counter with timeout detection.
module mc_wait_timer
    import mc_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired,
    output logic o_zero
);
    localparam int W = cnt_width(WAIT_TIMEOUT);
    localparam logic [W-1:0] LIMIT = W'(WAIT_TIMEOUT);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (WAIT_TIMEOUT != 0) && (r_cnt == LIMIT);
    assign o_zero    = (r_cnt == '0);
endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle RV32I control sequencer: strobes, mux selects and
// memory handshakes with timeout, illegal-opcode trap and debug halt.
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 15,
    parameter bit TRAP_EN      = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    mc_mem_if.master    mem,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        halt_req,
    output logic        ir_write,
    output logic        tgt_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  writeback_src,
    output logic        halted,
    output logic        trap,
    output logic [1:0]  trap_cause
);
    state_t      r_state;
    state_t      w_next;
    logic        r_trap;
    trap_cause_t r_cause;
    trap_cause_t w_cause;
    logic        w_imem_req;
    logic        w_dmem_req;
    logic        w_dmem_wren;
    logic        w_inc;
    logic        w_clr;
    logic        w_expired;
    logic        w_zero;

    mc_wait_timer #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) u_timer (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_clr     (w_clr),
        .i_inc     (w_inc),
        .o_expired (w_expired),
        .o_zero    (w_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_trap  <= 1'b0;
            r_cause <= CAUSE_NONE;
        end else begin
            r_state <= w_next;
            if (w_next == S_TRAP && r_state != S_TRAP) begin
                r_trap  <= 1'b1;
                r_cause <= w_cause;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_cause       = CAUSE_NONE;
        w_inc         = 1'b0;
        w_imem_req    = 1'b0;
        w_dmem_req    = 1'b0;
        w_dmem_wren   = 1'b0;
        ir_write      = 1'b0;
        tgt_write     = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_REG;
        writeback_src = WB_ALU;
        halted        = 1'b0;
        unique case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                if (halt_req && w_zero) begin
                    w_next = S_HALT;
                end else if (w_expired) begin
                    w_next  = S_TRAP;
                    w_cause = CAUSE_IMEM_TO;
                end else begin
                    w_imem_req = 1'b1;
                    if (mem.imem_ready) begin
                        ir_write = 1'b1;
                        w_next   = S_DECODE;
                    end else begin
                        w_inc = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_PC;
                alu_src_b = SRCB_IMM;
                tgt_write = 1'b1;
                if (op_legal(opcode)) begin
                    w_next = S_EXEC;
                end else if (TRAP_EN) begin
                    w_next  = S_TRAP;
                    w_cause = CAUSE_ILLEGAL;
                end else begin
                    pc_write = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_R: begin
                        alu_src_a = SRCA_REG;
                        w_next    = S_WB;
                    end
                    OP_IMM, OP_JALR: begin
                        alu_src_a = SRCA_REG;
                        alu_src_b = SRCB_IMM;
                        w_next    = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a = SRCA_REG;
                        alu_src_b = SRCB_IMM;
                        w_next    = S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_src_a = SRCA_REG;
                        pc_write  = 1'b1;
                        pc_src    = branch_taken;
                        w_next    = S_FETCH;
                    end
                    OP_JAL: begin
                        reg_write     = 1'b1;
                        writeback_src = WB_PC4;
                        pc_write      = 1'b1;
                        pc_src        = 1'b1;
                        w_next        = S_FETCH;
                    end
                    OP_LUI: w_next = S_WB;
                    OP_AUIPC: begin
                        alu_src_b = SRCB_IMM;
                        w_next    = S_WB;
                    end
                    default: begin
                        pc_write = 1'b1;
                        w_next   = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                if (w_expired) begin
                    w_next  = S_TRAP;
                    w_cause = CAUSE_DMEM_TO;
                end else begin
                    w_dmem_req  = 1'b1;
                    w_dmem_wren = (opcode == OP_STORE);
                    if (mem.dmem_ready) begin
                        if (opcode == OP_STORE) begin
                            pc_write = 1'b1;
                            w_next   = S_FETCH;
                        end else begin
                            w_next = S_WB;
                        end
                    end else begin
                        w_inc = 1'b1;
                    end
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                case (opcode)
                    OP_LOAD: writeback_src = WB_MEM;
                    OP_LUI:  writeback_src = WB_IMM;
                    OP_JALR: writeback_src = WB_PC4;
                    default: writeback_src = WB_ALU;
                endcase
                pc_write = 1'b1;
                pc_src   = (opcode == OP_JALR);
                w_next   = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (!halt_req) w_next = S_FETCH;
            end
            S_TRAP: w_next = S_TRAP;
            default: w_next = S_IDLE;
        endcase
    end

    // Any accepted ready also moves state, so the state-change term covers it.
    assign w_clr = (w_next != r_state)
                 || (w_imem_req && mem.imem_ready)
                 || (w_dmem_req && mem.dmem_ready);

    assign mem.imem_req  = w_imem_req;
    assign mem.dmem_req  = w_dmem_req;
    assign mem.dmem_wren = w_dmem_wren;
    assign trap          = r_trap;
    assign trap_cause    = r_cause;
endmodule

// File: tb/tb_mc_sequencer.sv
// Scoreboard bench for mc_sequencer: directed instruction sequences
// push expected per-cycle control vectors; a monitor pops and compares.
module tb_mc_sequencer;
    import mc_pkg::*;

    typedef struct packed {
        logic       im;
        logic       dm;
        logic       wr;
        logic       ir;
        logic       tg;
        logic       pw;
        logic       ps;
        logic       rw;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] wb;
        logic       h;
        logic       t;
        logic [1:0] c;
    } exp_t;

    typedef struct {
        string tag;
        exp_t  e;
    } item_t;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       halt_req;
    logic       ir_write;
    logic       tgt_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] writeback_src;
    logic       halted;
    logic       trap;
    logic [1:0] trap_cause;

    item_t q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    mc_mem_if mem_if();

    mc_sequencer #(.WAIT_TIMEOUT(15), .TRAP_EN(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem           (mem_if),
        .opcode        (opcode),
        .branch_taken  (branch_taken),
        .halt_req      (halt_req),
        .ir_write      (ir_write),
        .tgt_write     (tgt_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .writeback_src (writeback_src),
        .halted        (halted),
        .trap          (trap),
        .trap_cause    (trap_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t f_fetch(input logic rdy);
        exp_t e = '0;
        e.im = 1'b1;
        e.ir = rdy;
        return e;
    endfunction

    function automatic exp_t f_dec();
        exp_t e = '0;
        e.tg = 1'b1;
        e.b  = 2'b10;
        return e;
    endfunction

    function automatic exp_t f_ctl(input logic pw, input logic ps,
                                   input logic rw, input logic [1:0] a,
                                   input logic [1:0] b,
                                   input logic [1:0] wb);
        exp_t e = '0;
        e.pw = pw;
        e.ps = ps;
        e.rw = rw;
        e.a  = a;
        e.b  = b;
        e.wb = wb;
        return e;
    endfunction

    function automatic exp_t f_mem(input logic wr, input logic pw);
        exp_t e = '0;
        e.dm = 1'b1;
        e.wr = wr;
        e.pw = pw;
        return e;
    endfunction

    function automatic exp_t f_halt();
        exp_t e = '0;
        e.h = 1'b1;
        return e;
    endfunction

    function automatic exp_t f_trap(input logic [1:0] c);
        exp_t e = '0;
        e.t = 1'b1;
        e.c = c;
        return e;
    endfunction

    task automatic step(input string tag, input exp_t e);
        item_t it;
        it.tag = tag;
        it.e   = e;
        q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mem_if.imem_ready = 1'b0;
        mem_if.dmem_ready = 1'b0;
        halt_req = 1'b0;
        step("rst", '0);
        reset = 1'b1;
        step("idle", '0);
    endtask

    task automatic run_add(input string tag);
        opcode = OP_R;
        mem_if.imem_ready = 1'b1;
        step({tag, "_f"}, f_fetch(1'b1));
        mem_if.imem_ready = 1'b0;
        step({tag, "_d"}, f_dec());
        step({tag, "_x"}, f_ctl(0, 0, 0, 2'b01, 2'b00, 2'b00));
        step({tag, "_w"}, f_ctl(1, 0, 1, 2'b00, 2'b00, 2'b00));
    endtask

    task automatic fetch_dec(input string tag, input logic [6:0] op);
        opcode = op;
        mem_if.imem_ready = 1'b1;
        step({tag, "_f"}, f_fetch(1'b1));
        mem_if.imem_ready = 1'b0;
        step({tag, "_d"}, f_dec());
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            item_t it;
            exp_t  act;
            it = q.pop_front();
            act = {mem_if.imem_req, mem_if.dmem_req, mem_if.dmem_wren,
                   ir_write, tgt_write, pc_write, pc_src, reg_write,
                   alu_src_a, alu_src_b, writeback_src,
                   halted, trap, trap_cause};
            n_cmp++;
            if (act !== it.e) begin
                n_err++;
                $display("FAIL %s: got %05h expected %05h",
                         it.tag, act, it.e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        opcode = 7'd0;
        branch_taken = 1'b0;
        halt_req = 1'b0;
        mem_if.imem_ready = 1'b0;
        mem_if.dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        run_add("add");

        fetch_dec("lw", OP_LOAD);
        step("lw_x", f_ctl(0, 0, 0, 2'b01, 2'b10, 2'b00));
        for (int i = 0; i < 3; i++) step("lw_mwait", f_mem(0, 0));
        mem_if.dmem_ready = 1'b1;
        step("lw_mrdy", f_mem(0, 0));
        mem_if.dmem_ready = 1'b0;
        step("lw_w", f_ctl(1, 0, 1, 2'b00, 2'b00, 2'b01));

        fetch_dec("sw", OP_STORE);
        step("sw_x", f_ctl(0, 0, 0, 2'b01, 2'b10, 2'b00));
        mem_if.dmem_ready = 1'b1;
        step("sw_m", f_mem(1, 1));
        mem_if.dmem_ready = 1'b0;

        branch_taken = 1'b1;
        fetch_dec("beqt", OP_BRANCH);
        step("beqt_x", f_ctl(1, 1, 0, 2'b01, 2'b00, 2'b00));
        branch_taken = 1'b0;
        fetch_dec("beqn", OP_BRANCH);
        step("beqn_x", f_ctl(1, 0, 0, 2'b01, 2'b00, 2'b00));

        fetch_dec("jal", OP_JAL);
        step("jal_x", f_ctl(1, 1, 1, 2'b00, 2'b00, 2'b11));

        fetch_dec("jalr", OP_JALR);
        step("jalr_x", f_ctl(0, 0, 0, 2'b01, 2'b10, 2'b00));
        step("jalr_w", f_ctl(1, 1, 1, 2'b00, 2'b00, 2'b11));

        fetch_dec("lui", OP_LUI);
        step("lui_x", '0);
        step("lui_w", f_ctl(1, 0, 1, 2'b00, 2'b00, 2'b10));

        opcode = OP_AUIPC;
        step("aui_fw", f_fetch(1'b0));
        step("aui_fw", f_fetch(1'b0));
        mem_if.imem_ready = 1'b1;
        step("aui_f", f_fetch(1'b1));
        mem_if.imem_ready = 1'b0;
        step("aui_d", f_dec());
        step("aui_x", f_ctl(0, 0, 0, 2'b00, 2'b10, 2'b00));
        step("aui_w", f_ctl(1, 0, 1, 2'b00, 2'b00, 2'b00));

        // halt_req raised mid-instruction only takes effect at the next FETCH
        opcode = OP_IMM;
        mem_if.imem_ready = 1'b1;
        step("opi_f", f_fetch(1'b1));
        mem_if.imem_ready = 1'b0;
        halt_req = 1'b1;
        step("opi_d", f_dec());
        step("opi_x", f_ctl(0, 0, 0, 2'b01, 2'b10, 2'b00));
        step("opi_w", f_ctl(1, 0, 1, 2'b00, 2'b00, 2'b00));
        mem_if.imem_ready = 1'b1;
        step("hlt_f", '0);
        step("hlt_h", f_halt());
        step("hlt_h", f_halt());
        halt_req = 1'b0;
        step("hlt_rel", f_halt());
        run_add("resume");

        fetch_dec("ill", 7'b1111111);
        halt_req = 1'b1;
        mem_if.imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) step("ill_trap", f_trap(2'b01));
        do_reset();

        opcode = OP_R;
        for (int i = 0; i < 15; i++) step("ito_wait", f_fetch(1'b0));
        step("ito_exp", '0);
        step("ito_trap", f_trap(2'b10));
        mem_if.imem_ready = 1'b1;
        step("ito_sticky", f_trap(2'b10));
        step("ito_sticky", f_trap(2'b10));
        do_reset();

        fetch_dec("dto", OP_LOAD);
        step("dto_x", f_ctl(0, 0, 0, 2'b01, 2'b10, 2'b00));
        for (int i = 0; i < 15; i++) step("dto_wait", f_mem(0, 0));
        step("dto_exp", '0);
        step("dto_trap", f_trap(2'b11));
        step("dto_trap", f_trap(2'b11));
        do_reset();

        @(posedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
